// File: rtl/alu_reservation_station_pkg.sv
// Shared types and sizing for the ALU reservation station.
// The RS_ENTRY_t layout is shared by the dispatch, wakeup and issue paths.
package alu_reservation_station_pkg;

  localparam int RS_DEPTH_DEFAULT = 8;
  localparam int PHY_WIDTH        = 6;
  localparam int ROB_WIDTH        = 5;
  localparam int WB_PORTS         = 3;
  localparam int OP_WIDTH         = 4;

  typedef struct packed {
    logic [PHY_WIDTH-1:0] src1_tag;
    logic                 src1_ready;
    logic [PHY_WIDTH-1:0] src2_tag;
    logic                 src2_ready;
    logic [PHY_WIDTH-1:0] prd;
    logic [ROB_WIDTH-1:0] rob_id;
    logic [OP_WIDTH-1:0]  op;
  } RS_ENTRY_t;

  function automatic logic entry_ready(RS_ENTRY_t e);
    return e.src1_ready & e.src2_ready;
  endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// Dispatch, wakeup and issue bundle of the ALU reservation station.
// RS_PERF_CNT_EN adds the rs_full_cycles performance counter output.
interface alu_reservation_station_if;
  import alu_reservation_station_pkg::*;

  logic                               flush;
  logic                               dispatch_valid;
  RS_ENTRY_t                          dispatch_entry;
  logic                               rs_full;
  logic [WB_PORTS-1:0]                wb_valid;
  logic [WB_PORTS-1:0][PHY_WIDTH-1:0] wb_prd;
  RS_ENTRY_t                          issue_instruction_alu;
  logic                               issue_alu_valid;
`ifdef RS_PERF_CNT_EN
  logic [31:0]                        rs_full_cycles;

  modport master (
    output flush, dispatch_valid, dispatch_entry, wb_valid, wb_prd,
    input  rs_full, issue_instruction_alu, issue_alu_valid, rs_full_cycles
  );
  modport slave (
    input  flush, dispatch_valid, dispatch_entry, wb_valid, wb_prd,
    output rs_full, issue_instruction_alu, issue_alu_valid, rs_full_cycles
  );
`else
  modport master (
    output flush, dispatch_valid, dispatch_entry, wb_valid, wb_prd,
    input  rs_full, issue_instruction_alu, issue_alu_valid
  );
  modport slave (
    input  flush, dispatch_valid, dispatch_entry, wb_valid, wb_prd,
    output rs_full, issue_instruction_alu, issue_alu_valid
  );
`endif

endinterface

// File: rtl/alu_reservation_station_rs_wakeup_cmp.sv
// Matches one source tag against every wakeup broadcast port.
module rs_wakeup_cmp import alu_reservation_station_pkg::*; (
  input  logic [PHY_WIDTH-1:0]               tag_i,
  input  logic [WB_PORTS-1:0]                wb_valid_i,
  input  logic [WB_PORTS-1:0][PHY_WIDTH-1:0] wb_prd_i,
  output logic                               hit_o
);

  always_comb begin
    hit_o = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid_i[p] && (wb_prd_i[p] == tag_i)) hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Collapsing, age-ordered ALU reservation station: slot 0 is oldest, oldest ready entry issues.
// Optional macro RS_PERF_CNT_EN adds a saturating count of cycles spent full.
module alu_reservation_station import alu_reservation_station_pkg::*; #(
  parameter int RS_DEPTH = RS_DEPTH_DEFAULT
) (
  input logic                      clk,
  input logic                      rst,
  alu_reservation_station_if.slave rs_if
);

  localparam int CNT_W = $clog2(RS_DEPTH + 1);
  localparam int IDX_W = $clog2(RS_DEPTH);

  RS_ENTRY_t            slots_q [RS_DEPTH];
  RS_ENTRY_t            slots_d [RS_DEPTH];
  RS_ENTRY_t            woken   [RS_DEPTH+1];
  RS_ENTRY_t            disp_woken;
  logic [CNT_W-1:0]     count_q, count_d, tail;
  logic [RS_DEPTH:0]    hit1, hit2;
  logic                 issue_fire, accept, rs_full;
  logic [IDX_W-1:0]     issue_idx;
  RS_ENTRY_t            issue_q;
  logic                 issue_valid_q;

  // Index RS_DEPTH of the comparator array serves the incoming dispatch entry.
  for (genvar g = 0; g <= RS_DEPTH; g++) begin : g_cmp
    logic [PHY_WIDTH-1:0] t1, t2;
    if (g < RS_DEPTH) begin : g_slot
      assign t1 = slots_q[g].src1_tag;
      assign t2 = slots_q[g].src2_tag;
    end else begin : g_disp
      assign t1 = rs_if.dispatch_entry.src1_tag;
      assign t2 = rs_if.dispatch_entry.src2_tag;
    end
    rs_wakeup_cmp u_cmp1 (.tag_i(t1), .wb_valid_i(rs_if.wb_valid), .wb_prd_i(rs_if.wb_prd), .hit_o(hit1[g]));
    rs_wakeup_cmp u_cmp2 (.tag_i(t2), .wb_valid_i(rs_if.wb_valid), .wb_prd_i(rs_if.wb_prd), .hit_o(hit2[g]));
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      woken[i]            = slots_q[i];
      woken[i].src1_ready = slots_q[i].src1_ready | hit1[i];
      woken[i].src2_ready = slots_q[i].src2_ready | hit2[i];
    end
    woken[RS_DEPTH]       = '0;
    disp_woken            = rs_if.dispatch_entry;
    disp_woken.src1_ready = rs_if.dispatch_entry.src1_ready | hit1[RS_DEPTH];
    disp_woken.src2_ready = rs_if.dispatch_entry.src2_ready | hit2[RS_DEPTH];
  end

  // Select uses registered ready bits only, so a wakeup becomes selectable next cycle.
  always_comb begin
    issue_fire = 1'b0;
    issue_idx  = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < count_q) && entry_ready(slots_q[i])) begin
        issue_fire = 1'b1;
        issue_idx  = IDX_W'(i);
      end
    end
  end

  assign rs_full = (count_q == CNT_W'(RS_DEPTH));
  assign accept  = rs_if.dispatch_valid && !rs_full && !rs_if.flush;
  assign tail    = count_q - CNT_W'(issue_fire);
  assign count_d = count_q + CNT_W'(accept) - CNT_W'(issue_fire);

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      slots_d[i] = woken[i];
      if (issue_fire && (IDX_W'(i) >= issue_idx)) slots_d[i] = woken[i+1];
      if (accept && (CNT_W'(i) == tail)) slots_d[i] = disp_woken;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q       <= '0;
      issue_q       <= '0;
      issue_valid_q <= 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) slots_q[i] <= '0;
    end else if (rs_if.flush) begin
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) slots_q[i] <= '0;
    end else begin
      count_q       <= count_d;
      issue_valid_q <= issue_fire;
      if (issue_fire) issue_q <= slots_q[issue_idx];
      for (int i = 0; i < RS_DEPTH; i++) slots_q[i] <= slots_d[i];
    end
  end

  assign rs_if.rs_full               = rs_full;
  assign rs_if.issue_instruction_alu = issue_q;
  assign rs_if.issue_alu_valid       = issue_valid_q;

`ifdef RS_PERF_CNT_EN
  logic [31:0] full_cycles_q;

  // Survives flush on purpose; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_cycles_q <= '0;
    end else if (rs_full && (full_cycles_q != 32'hFFFF_FFFF)) begin
      full_cycles_q <= full_cycles_q + 32'd1;
    end
  end

  assign rs_if.rs_full_cycles = full_cycles_q;
`endif

  assert property (@(posedge clk) disable iff (!rst)
    !(rs_if.dispatch_valid && rs_full && !rs_if.flush))
    else $error("dispatch presented while rs_full; entry dropped");

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  localparam int DEPTH = RS_DEPTH_DEFAULT;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_reservation_station_if rs_if ();

  alu_reservation_station #(.RS_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .rs_if (rs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: age-ordered queue, front is oldest.
  RS_ENTRY_t   mq[$];
  logic        exp_valid;
  RS_ENTRY_t   exp_instr;
  logic [31:0] exp_perf;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic RS_ENTRY_t mk(int s1, bit r1, int s2, bit r2, int rob);
    RS_ENTRY_t e;
    e.src1_tag   = PHY_WIDTH'(s1);
    e.src1_ready = r1;
    e.src2_tag   = PHY_WIDTH'(s2);
    e.src2_ready = r2;
    e.prd        = PHY_WIDTH'(rob + 32);
    e.rob_id     = ROB_WIDTH'(rob);
    e.op         = OP_WIDTH'(rob);
    return e;
  endfunction

  function automatic RS_ENTRY_t wake(RS_ENTRY_t e);
    for (int p = 0; p < WB_PORTS; p++) begin
      if (rs_if.wb_valid[p]) begin
        if (rs_if.wb_prd[p] == e.src1_tag) e.src1_ready = 1'b1;
        if (rs_if.wb_prd[p] == e.src2_tag) e.src2_ready = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic idle();
    rs_if.flush          = 1'b0;
    rs_if.dispatch_valid = 1'b0;
    rs_if.dispatch_entry = '0;
    rs_if.wb_valid       = '0;
    rs_if.wb_prd         = '0;
  endtask

  task automatic model_step();
    int  sel;
    bit  was_full;
    was_full = (mq.size() == DEPTH);
    if (was_full && exp_perf != 32'hFFFF_FFFF) exp_perf++;
    if (rs_if.flush) begin
      mq.delete();
      exp_valid = 1'b0;
      return;
    end
    sel = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].src1_ready && mq[i].src2_ready) begin
        sel = i;
        break;
      end
    end
    for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
    if (sel >= 0) begin
      exp_instr = mq[sel];
      exp_valid = 1'b1;
      mq.delete(sel);
    end else begin
      exp_valid = 1'b0;
    end
    if (rs_if.dispatch_valid && !was_full) mq.push_back(wake(rs_if.dispatch_entry));
  endtask

  // Inputs are driven 1 time unit after a rising edge and checked 1 unit after the next.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("valid", 64'(rs_if.issue_alu_valid), 64'(exp_valid));
    chk("instr", 64'(rs_if.issue_instruction_alu), 64'(exp_instr));
    chk("full", 64'(rs_if.rs_full), 64'(mq.size() == DEPTH));
`ifdef RS_PERF_CNT_EN
    chk("perf", 64'(rs_if.rs_full_cycles), 64'(exp_perf));
`endif
    idle();
  endtask

  task automatic dispatch(RS_ENTRY_t e);
    rs_if.dispatch_valid = 1'b1;
    rs_if.dispatch_entry = e;
  endtask

  task automatic reset_mid();
    #3 rst = 1'b0;
    #1;
    mq.delete();
    exp_valid = 1'b0;
    exp_instr = '0;
    exp_perf  = '0;
    chk("rst_valid", 64'(rs_if.issue_alu_valid), 64'(0));
    chk("rst_instr", 64'(rs_if.issue_instruction_alu), 64'(0));
    chk("rst_full", 64'(rs_if.rs_full), 64'(0));
`ifdef RS_PERF_CNT_EN
    chk("rst_perf", 64'(rs_if.rs_full_cycles), 64'(0));
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    exp_valid = 1'b0;
    exp_instr = '0;
    exp_perf  = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", 64'(rs_if.issue_alu_valid), 64'(0));
    chk("init_instr", 64'(rs_if.issue_instruction_alu), 64'(0));
    chk("init_full", 64'(rs_if.rs_full), 64'(0));
    rst = 1'b1;

    // Ready dispatch in cycle 1 issues in cycle 3.
    dispatch(mk(1, 1, 2, 1, 3));
    cycle();
    chk("rdy_c2_v", 64'(rs_if.issue_alu_valid), 64'(0));
    cycle();
    chk("rdy_c3_v", 64'(rs_if.issue_alu_valid), 64'(1));
    chk("rdy_c3_rob", 64'(rs_if.issue_instruction_alu.rob_id), 64'(3));
    cycle();
    chk("rdy_c4_v", 64'(rs_if.issue_alu_valid), 64'(0));

    // Oldest-first: A waits on tag 10, B and C bypass it.
    dispatch(mk(1, 1, 10, 0, 4));
    cycle();
    dispatch(mk(2, 1, 3, 1, 5));
    cycle();
    dispatch(mk(4, 1, 5, 1, 6));
    cycle();
    chk("ord_b", 64'(rs_if.issue_instruction_alu.rob_id), 64'(5));
    rs_if.wb_valid[0] = 1'b1;
    rs_if.wb_prd[0]   = 6'd10;
    cycle();
    chk("ord_c", 64'(rs_if.issue_instruction_alu.rob_id), 64'(6));
    cycle();
    chk("ord_a_v", 64'(rs_if.issue_alu_valid), 64'(1));
    chk("ord_a", 64'(rs_if.issue_instruction_alu.rob_id), 64'(4));
    cycle();

    // Wakeup coinciding with dispatch stores the entry ready.
    dispatch(mk(7, 0, 8, 1, 9));
    rs_if.wb_valid[1] = 1'b1;
    rs_if.wb_prd[1]   = 6'd7;
    cycle();
    chk("dw_n1_v", 64'(rs_if.issue_alu_valid), 64'(0));
    cycle();
    chk("dw_n2_v", 64'(rs_if.issue_alu_valid), 64'(1));
    chk("dw_n2_rob", 64'(rs_if.issue_instruction_alu.rob_id), 64'(9));

    // Fill with eight blocked entries, then wake the oldest.
    for (int i = 0; i < DEPTH; i++) begin
      dispatch(mk(20 + i, 0, 50, 1, 10 + i));
      cycle();
    end
    chk("full_set", 64'(rs_if.rs_full), 64'(1));
    rs_if.wb_valid[2] = 1'b1;
    rs_if.wb_prd[2]   = 6'd20;
    cycle();
    chk("full_w1_v", 64'(rs_if.issue_alu_valid), 64'(0));
    chk("full_w1_f", 64'(rs_if.rs_full), 64'(1));
    cycle();
    chk("full_w2_v", 64'(rs_if.issue_alu_valid), 64'(1));
    chk("full_w2_rob", 64'(rs_if.issue_instruction_alu.rob_id), 64'(10));
    chk("full_w2_f", 64'(rs_if.rs_full), 64'(0));
    rs_if.flush = 1'b1;
    cycle();

    // Flush with five entries, two of them ready, and a concurrent dispatch.
    for (int i = 0; i < 5; i++) begin
      dispatch(mk((i < 2) ? 30 : 31 + i, 0, 50, 1, 20 + i));
      cycle();
    end
    rs_if.wb_valid[0] = 1'b1;
    rs_if.wb_prd[0]   = 6'd30;
    cycle();
    rs_if.flush = 1'b1;
    dispatch(mk(1, 1, 2, 1, 25));
    cycle();
    for (int i = 0; i < 4; i++) begin
      chk("flush_v", 64'(rs_if.issue_alu_valid), 64'(0));
      cycle();
    end

    // Async reset while an issue is visible and four entries remain.
    for (int i = 0; i < 5; i++) begin
      dispatch(mk(40 + i, (i == 3), 50, 1, (i == 3) ? 20 : 26 + i));
      cycle();
    end
    chk("pre_rst_v", 64'(rs_if.issue_alu_valid), 64'(1));
    chk("pre_rst_rob", 64'(rs_if.issue_instruction_alu.rob_id), 64'(20));
    reset_mid();
    dispatch(mk(1, 1, 2, 1, 21));
    cycle();
    chk("post_rst_n1", 64'(rs_if.issue_alu_valid), 64'(0));
    cycle();
    chk("post_rst_n2", 64'(rs_if.issue_alu_valid), 64'(1));
    chk("post_rst_rob", 64'(rs_if.issue_instruction_alu.rob_id), 64'(21));

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      RS_ENTRY_t e;
      e            = RS_ENTRY_t'($urandom);
      e.src1_tag   = PHY_WIDTH'($urandom_range(0, 15));
      e.src2_tag   = PHY_WIDTH'($urandom_range(0, 15));
      e.src1_ready = ($urandom_range(0, 99) < 45);
      e.src2_ready = ($urandom_range(0, 99) < 45);
      if (mq.size() < DEPTH && $urandom_range(0, 99) < 60) dispatch(e);
      for (int p = 0; p < WB_PORTS; p++) begin
        rs_if.wb_valid[p] = ($urandom_range(0, 99) < 35);
        rs_if.wb_prd[p]   = PHY_WIDTH'($urandom_range(0, 15));
      end
      rs_if.flush = ($urandom_range(0, 99) < 2);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
